// File: rtl/switch_debouncer.sv
// Eight-group DIP switch debouncer.
// Each 8-bit raw group is synchronised through three register stages. A
// per-group counter measures how long the synchronised value has been steady
// while differing from the accepted value; once it has been steady for
// DEBOUNCE_CYCLES consecutive edges the whole byte is accepted at once and a
// one-cycle change pulse is raised for that group.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_switch0,
  input  logic [7:0] raw_switch1,
  input  logic [7:0] raw_switch2,
  input  logic [7:0] raw_switch3,
  input  logic [7:0] raw_switch4,
  input  logic [7:0] raw_switch5,
  input  logic [7:0] raw_switch6,
  input  logic [7:0] raw_switch7,
  output logic [7:0] stable_switch0,
  output logic [7:0] stable_switch1,
  output logic [7:0] stable_switch2,
  output logic [7:0] stable_switch3,
  output logic [7:0] stable_switch4,
  output logic [7:0] stable_switch5,
  output logic [7:0] stable_switch6,
  output logic [7:0] stable_switch7,
  output logic [7:0] change_mask,
  output logic       any_change
);

  // Final count value: reaching it while still steady means "accept now".
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Switches are active-low, so the idle / reset value is all-open.
  localparam logic [7:0] ALL_OPEN = 8'hFF;

  logic [7:0]           raw    [8];
  logic [7:0]           sync1  [8];
  logic [7:0]           sync2  [8];
  logic [7:0]           sync3  [8];
  logic [7:0]           stable [8];
  logic [CNT_WIDTH-1:0] cnt    [8];

  // Per-group decode of this edge's action.
  logic [7:0] restart;
  logic [7:0] accept;

  assign raw[0] = raw_switch0;
  assign raw[1] = raw_switch1;
  assign raw[2] = raw_switch2;
  assign raw[3] = raw_switch3;
  assign raw[4] = raw_switch4;
  assign raw[5] = raw_switch5;
  assign raw[6] = raw_switch6;
  assign raw[7] = raw_switch7;

  // Outputs come straight from the accepted-value registers.
  assign stable_switch0 = stable[0];
  assign stable_switch1 = stable[1];
  assign stable_switch2 = stable[2];
  assign stable_switch3 = stable[3];
  assign stable_switch4 = stable[4];
  assign stable_switch5 = stable[5];
  assign stable_switch6 = stable[6];
  assign stable_switch7 = stable[7];

  // Decide per group: restart the window, keep counting, or accept.
  always_comb begin
    restart = '0;
    accept  = '0;
    for (int g = 0; g < 8; g++) begin
      // Nothing new to debounce, or the candidate moved: start over.
      restart[g] = (sync2[g] == stable[g]) || (sync2[g] != sync3[g]);
      // Steady for the full window: the counter sits at its last value.
      accept[g]  = !restart[g] && !(cnt[g] < CNT_LAST);
    end
  end

  // Synchronisers, per-group counters, accepted values and change pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 8; g++) begin
        sync1[g]  <= ALL_OPEN;
        sync2[g]  <= ALL_OPEN;
        sync3[g]  <= ALL_OPEN;
        stable[g] <= ALL_OPEN;
        cnt[g]    <= '0;
      end
      change_mask <= '0;
      any_change  <= 1'b0;
    end else begin
      for (int g = 0; g < 8; g++) begin
        sync1[g] <= raw[g];
        sync2[g] <= sync1[g];
        sync3[g] <= sync2[g];
        if (restart[g]) begin
          cnt[g] <= '0;
        end else if (accept[g]) begin
          // Whole byte taken at once, so multi-bit changes stay atomic.
          stable[g] <= sync2[g];
          cnt[g]    <= '0;
        end else begin
          cnt[g] <= cnt[g] + CNT_WIDTH'(1);
        end
      end
      change_mask <= accept;
      any_change  <= |accept;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer (DEBOUNCE_CYCLES=4).
// Reference model: every edge records the byte each group's first sync stage
// captures. A group accepts value v at edge n when the captures at edges
// n-D-2 .. n-2 are all v, v differs from the current accepted value, and
// reset was not active at edge n-1 or n.
module tb_switch_debouncer;

  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw  [8];
  logic [7:0] stab [8];
  logic [7:0] change_mask;
  logic       any_change;

  int total = 0;
  int bad   = 0;
  int n     = -1;

  logic [7:0] h [8][MAXE];
  bit         rh [MAXE];
  logic [7:0] stable_m [8];
  logic [7:0] mask_m;

  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .raw_switch0    (raw[0]),
    .raw_switch1    (raw[1]),
    .raw_switch2    (raw[2]),
    .raw_switch3    (raw[3]),
    .raw_switch4    (raw[4]),
    .raw_switch5    (raw[5]),
    .raw_switch6    (raw[6]),
    .raw_switch7    (raw[7]),
    .stable_switch0 (stab[0]),
    .stable_switch1 (stab[1]),
    .stable_switch2 (stab[2]),
    .stable_switch3 (stab[3]),
    .stable_switch4 (stab[4]),
    .stable_switch5 (stab[5]),
    .stable_switch6 (stab[6]),
    .stable_switch7 (stab[7]),
    .change_mask    (change_mask),
    .any_change     (any_change)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, edge=%0d", n);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // One clock edge: update the model from the applied inputs, then compare.
  task automatic tick();
    logic [7:0] v;
    bit         ok;
    @(posedge clk);
    n++;
    if (n >= MAXE) begin
      $display("FAIL edge_budget: observed=%0d expected<%0d", n, MAXE);
      $fatal(1, "edge budget");
    end
    rh[n]  = rst;
    mask_m = '0;
    for (int g = 0; g < 8; g++) h[g][n] = rst ? 8'hFF : raw[g];
    if (rst) begin
      for (int g = 0; g < 8; g++) stable_m[g] = 8'hFF;
    end else if (n >= D + 2 && !rh[n-1]) begin
      for (int g = 0; g < 8; g++) begin
        v  = h[g][n-2];
        ok = 1'b1;
        for (int k = n - D - 2; k <= n - 2; k++) if (h[g][k] !== v) ok = 1'b0;
        if (ok && v != stable_m[g]) begin
          stable_m[g] = v;
          mask_m[g]   = 1'b1;
        end
      end
    end
    #1;
    for (int g = 0; g < 8; g++) check($sformatf("stable%0d", g), stab[g], stable_m[g]);
    check("change_mask", change_mask, mask_m);
    check("any_change", {7'd0, any_change}, {7'd0, |mask_m});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    int pulses;
    int pulse_at;
    int hold [8];

    for (int g = 0; g < 8; g++) raw[g] = 8'hFF;
    rst = 1'b1;
    idle(3);
    check("reset_mask", change_mask, 8'h00);
    check("reset_stable0", stab[0], 8'hFF);
    rst = 1'b0;
    idle(4);

    // Single press on group 0: accepted at edge D+2 counted from first sample.
    raw[0] = 8'hFE;
    for (int e = 0; e <= 5; e++) begin
      tick();
      check("step_hold_ff", stab[0], 8'hFF);
    end
    tick();
    check("step_value", stab[0], 8'hFE);
    check("step_mask", change_mask, 8'h01);
    check("step_any", {7'd0, any_change}, 8'h01);
    tick();
    check("step_mask_clear", change_mask, 8'h00);
    raw[0] = 8'hFF;
    idle(12);

    // Three-cycle glitch on group 3 must be ignored.
    pulses = 0;
    raw[3] = 8'h7F;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(change_mask[3]); end
    raw[3] = 8'hFF;
    for (int i = 0; i < 12; i++) begin tick(); pulses += int'(change_mask[3]); end
    check("glitch_pulses", 8'(pulses), 8'd0);
    check("glitch_stable", stab[3], 8'hFF);

    // Bouncing group 5 settles on F0, accepted once, 6 edges after last toggle.
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < 25; i++) begin
      if (i < 10) raw[5] = ((i / 2) % 2 == 1) ? 8'hFF : 8'hF0;
      else        raw[5] = 8'hF0;
      tick();
      if (change_mask[5]) begin pulses++; pulse_at = i; end
    end
    check("bounce_pulses", 8'(pulses), 8'd1);
    check("bounce_edge", 8'(pulse_at), 8'd14);
    check("bounce_value", stab[5], 8'hF0);
    raw[5] = 8'hFF;
    idle(12);

    // Simultaneous acceptance in groups 7 and 1.
    raw[7] = 8'h00;
    raw[1] = 8'h0F;
    idle(6);
    tick();
    check("simul_mask", change_mask, 8'h82);
    check("simul_g7", stab[7], 8'h00);
    check("simul_g1", stab[1], 8'h0F);
    raw[7] = 8'hFF;
    raw[1] = 8'hFF;
    idle(12);

    // Reset in the middle of a count discards it; the change restarts cleanly.
    raw[0] = 8'hFE;
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_stable", stab[0], 8'hFF);
    check("midrst_mask", change_mask, 8'h00);
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin tick(); pulses += int'(change_mask[0]); end
    check("midrst_early", 8'(pulses), 8'd0);
    tick();
    check("midrst_mask_late", change_mask, 8'h01);
    check("midrst_value", stab[0], 8'hFE);
    raw[0] = 8'hFF;
    idle(12);

    // Random phase: per-group hold times around the window length, rare resets.
    for (int g = 0; g < 8; g++) hold[g] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int g = 0; g < 8; g++) begin
        if (hold[g] == 0) begin
          case ($urandom_range(0, 3))
            0:       raw[g] = 8'hFF;
            1:       raw[g] = 8'hFE;
            2:       raw[g] = 8'h00;
            default: raw[g] = 8'($urandom);
          endcase
          hold[g] = $urandom_range(1, 9);
        end else begin
          hold[g]--;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
